// File: rtl/cw305_reg_ml_mac.sv
// cw305_reg_ml_mac: byte-addressed ML register block with a sequential single-MAC perceptron layer.
// Optional feature macro ML_ACC_READBACK_EN adds read-only register 0x09 ACC (final accumulators).

module cw305_reg_ml_mac #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pDW           = 8,
  parameter int pINPUTCNT     = 4,
  parameter int pOUTPUTCNT    = 4,
  parameter int pACCW         = 20
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_i,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int AW    = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int IN_W  = pINPUTCNT * pDW;
  localparam int IN_B  = (IN_W + 7) / 8;
  localparam int WT_W  = pOUTPUTCNT * pINPUTCNT * pDW;
  localparam int WT_B  = (WT_W + 7) / 8;
  localparam int BI_W  = pOUTPUTCNT * pACCW;
  localparam int BI_B  = (BI_W + 7) / 8;
  localparam int OUT_B = (pOUTPUTCNT + 7) / 8;
  localparam int MAXB0 = (IN_B > WT_B) ? IN_B : WT_B;
  localparam int MAXB1 = (MAXB0 > BI_B) ? MAXB0 : BI_B;
  localparam int MAXB  = (MAXB1 > OUT_B) ? MAXB1 : OUT_B;
  localparam int NW    = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;
  localparam int IW    = (pINPUTCNT > 1) ? $clog2(pINPUTCNT) : 1;

  localparam logic [AW-1:0] ADDR_INPUTS  = AW'(4);
  localparam logic [AW-1:0] ADDR_WEIGHTS = AW'(5);
  localparam logic [AW-1:0] ADDR_BIAS    = AW'(6);
  localparam logic [AW-1:0] ADDR_OUTPUTS = AW'(7);
  localparam logic [AW-1:0] ADDR_CTRL    = AW'(8);
`ifdef ML_ACC_READBACK_EN
  localparam logic [AW-1:0] ADDR_ACC     = AW'(9);
`endif

  // Fields are stored byte-padded; the masks keep the padding bits of a partial top byte at zero.
  localparam logic [IN_B*8-1:0] IN_MASK = ~({(IN_B*8){1'b1}} << IN_W);
  localparam logic [WT_B*8-1:0] WT_MASK = ~({(WT_B*8){1'b1}} << WT_W);
  localparam logic [BI_B*8-1:0] BI_MASK = ~({(BI_B*8){1'b1}} << BI_W);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_MAC, ST_STORE, ST_DONE} state_t;

  state_t                   state_reg, state_next;
  logic [IN_B*8-1:0]        in_reg;
  logic [WT_B*8-1:0]        wt_reg;
  logic [BI_B*8-1:0]        bias_reg;
  logic [pOUTPUTCNT-1:0]    shadow_reg;
  logic [pOUTPUTCNT-1:0]    out_reg;
  logic [OUT_B*8-1:0]       out_pad;
  logic signed [pACCW-1:0]  acc_reg;
  logic [NW-1:0]            n_reg;
  logic [IW-1:0]            i_reg;
  logic                     done_reg;
  logic [7:0]               rd_next;

  logic [MAXB-1:0]          byte_sel;
  logic                     wr_en, rd_en, busy;
  logic                     wr_in, wr_wt, wr_bias, wr_ctrl;
  logic                     go_cmd, clr_cmd;
  logic                     i_last, n_last;

  logic signed [pDW-1:0]    in_arr   [pINPUTCNT];
  logic signed [pDW-1:0]    wt_arr   [pOUTPUTCNT][pINPUTCNT];
  logic signed [pACCW-1:0]  bias_arr [pOUTPUTCNT];
  logic signed [2*pDW-1:0]  prod;
  logic signed [pACCW-1:0]  prod_ext;

  // One-hot decode of the byte index shared by all fields.
  for (genvar gi = 0; gi < MAXB; gi++) begin : g_bsel
    assign byte_sel[gi] = (reg_bytecnt == pBYTECNT_SIZE'(gi));
  end

  assign wr_en   = reg_write & reg_addrvalid;
  assign rd_en   = reg_read & reg_addrvalid;
  assign busy    = (state_reg != ST_IDLE);
  assign wr_in   = wr_en & ~busy & (reg_address == ADDR_INPUTS);
  assign wr_wt   = wr_en & ~busy & (reg_address == ADDR_WEIGHTS);
  assign wr_bias = wr_en & ~busy & (reg_address == ADDR_BIAS);
  assign wr_ctrl = wr_en & (reg_address == ADDR_CTRL) & byte_sel[0];
  assign go_cmd  = wr_ctrl & write_data[0] & ~busy;
  assign clr_cmd = wr_ctrl & write_data[1];

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      in_reg   <= '0;
      wt_reg   <= '0;
      bias_reg <= '0;
    end else begin
      for (int k = 0; k < IN_B; k++)
        if (wr_in && byte_sel[k]) in_reg[8*k +: 8] <= write_data & IN_MASK[8*k +: 8];
      for (int k = 0; k < WT_B; k++)
        if (wr_wt && byte_sel[k]) wt_reg[8*k +: 8] <= write_data & WT_MASK[8*k +: 8];
      for (int k = 0; k < BI_B; k++)
        if (wr_bias && byte_sel[k]) bias_reg[8*k +: 8] <= write_data & BI_MASK[8*k +: 8];
    end
  end

  for (genvar gi = 0; gi < pINPUTCNT; gi++) begin : g_in
    assign in_arr[gi] = in_reg[gi*pDW +: pDW];
  end

  for (genvar gi = 0; gi < pOUTPUTCNT; gi++) begin : g_neuron
    assign bias_arr[gi] = bias_reg[gi*pACCW +: pACCW];
    for (genvar gj = 0; gj < pINPUTCNT; gj++) begin : g_w
      assign wt_arr[gi][gj] = wt_reg[(gi*pINPUTCNT + gj)*pDW +: pDW];
    end
  end

  assign prod     = in_arr[i_reg] * wt_arr[n_reg][i_reg];
  assign prod_ext = pACCW'(prod);
  assign i_last   = (i_reg == IW'(pINPUTCNT - 1));
  assign n_last   = (n_reg == NW'(pOUTPUTCNT - 1));

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (go_cmd) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_MAC;
      ST_MAC:   if (i_last) state_next = ST_STORE;
      ST_STORE: state_next = n_last ? ST_DONE : ST_LOAD;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Results are built in shadow_reg so OUTPUTS only ever change as a complete set.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      acc_reg    <= '0;
      n_reg      <= '0;
      i_reg      <= '0;
      shadow_reg <= '0;
      out_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (go_cmd) begin
            n_reg <= '0;
            i_reg <= '0;
          end
        end
        ST_LOAD: begin
          acc_reg <= bias_arr[n_reg];
          i_reg   <= '0;
        end
        ST_MAC: begin
          acc_reg <= acc_reg + prod_ext;
          i_reg   <= i_reg + IW'(1);
        end
        ST_STORE: begin
          shadow_reg[n_reg] <= ~acc_reg[pACCW-1] & (|acc_reg);
          n_reg             <= n_reg + NW'(1);
        end
        ST_DONE: out_reg <= shadow_reg;
        default: ;
      endcase
    end
  end

  // Go clears done even when clear is written alongside it.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)                   done_reg <= 1'b0;
    else if (state_reg == ST_DONE) done_reg <= 1'b1;
    else if (go_cmd || clr_cmd)    done_reg <= 1'b0;
  end

  assign out_pad = (OUT_B*8)'(out_reg);

`ifdef ML_ACC_READBACK_EN
  logic signed [pACCW-1:0] acc_sh [pOUTPUTCNT];
  logic [BI_W-1:0]         acc_pack;
  logic [BI_B*8-1:0]       acc_out_reg;

  for (genvar gi = 0; gi < pOUTPUTCNT; gi++) begin : g_accpack
    assign acc_pack[gi*pACCW +: pACCW] = acc_sh[gi];
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < pOUTPUTCNT; k++) acc_sh[k] <= '0;
      acc_out_reg <= '0;
    end else begin
      if (state_reg == ST_STORE) acc_sh[n_reg] <= acc_reg;
      if (state_reg == ST_DONE)  acc_out_reg   <= (BI_B*8)'(acc_pack);
    end
  end
`endif

  always_comb begin
    rd_next = 8'h00;
    case (reg_address)
      ADDR_INPUTS:
        for (int k = 0; k < IN_B; k++) if (byte_sel[k]) rd_next = in_reg[8*k +: 8];
      ADDR_WEIGHTS:
        for (int k = 0; k < WT_B; k++) if (byte_sel[k]) rd_next = wt_reg[8*k +: 8];
      ADDR_BIAS:
        for (int k = 0; k < BI_B; k++) if (byte_sel[k]) rd_next = bias_reg[8*k +: 8];
      ADDR_OUTPUTS:
        for (int k = 0; k < OUT_B; k++) if (byte_sel[k]) rd_next = out_pad[8*k +: 8];
      ADDR_CTRL:
        if (byte_sel[0]) rd_next = {6'b0, done_reg, busy};
`ifdef ML_ACC_READBACK_EN
      ADDR_ACC:
        for (int k = 0; k < BI_B; k++) if (byte_sel[k]) rd_next = acc_out_reg[8*k +: 8];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)    read_data <= 8'h00;
    else if (rd_en) read_data <= rd_next;
  end

  assign busy_o = busy;
  assign done_o = done_reg;

endmodule
